// File: rtl/seg_display_arbiter_pkg.sv
// Shared constants, types and helpers for the multiplexed 7-segment display arbiter.
// Frame layout: [27:21] is digit0 (leftmost) down to [6:0] for digit3.
package seg_disp_pkg;

    localparam int DIGITS  = 4;
    localparam int SEG_W   = 7;
    localparam int FRAME_W = DIGITS * SEG_W;

    localparam logic [DIGITS-1:0] COM_OFF = 4'b1111;
    localparam logic [DIGITS-1:0] COM_D0  = 4'b0111;
    localparam logic [DIGITS-1:0] COM_D1  = 4'b1011;
    localparam logic [DIGITS-1:0] COM_D2  = 4'b1101;
    localparam logic [DIGITS-1:0] COM_D3  = 4'b1110;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_t;

    function automatic logic [DIGITS-1:0] com_enc(input logic [1:0] digit);
        logic [DIGITS-1:0] com;
        case (digit)
            2'd0:    com = COM_D0;
            2'd1:    com = COM_D1;
            2'd2:    com = COM_D2;
            default: com = COM_D3;
        endcase
        return com;
    endfunction

    function automatic logic [SEG_W-1:0] digit_slice(input logic [FRAME_W-1:0] frame,
                                                     input logic [1:0]         digit);
        logic [SEG_W-1:0] seg;
        case (digit)
            2'd0:    seg = frame[27:21];
            2'd1:    seg = frame[20:14];
            2'd2:    seg = frame[13:7];
            default: seg = frame[6:0];
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Bundle of source requests/frames, the grant vector and the display pin drive.
// The arbiter takes the slave side; the frame sources and the board take the master side.
interface seg_display_arbiter_if
    import seg_disp_pkg::*;
#(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*FRAME_W-1:0] frame_i;
    logic [N_REQ-1:0]         grant;
    logic [SEG_W-1:0]         seg;
    logic [DIGITS-1:0]        com;
    logic                     frame_tick;

    modport master (
        output req,
        output frame_i,
        input  grant,
        input  seg,
        input  com,
        input  frame_tick
    );

    modport slave (
        input  req,
        input  frame_i,
        output grant,
        output seg,
        output com,
        output frame_tick
    );
endinterface

// File: rtl/seg_display_arbiter_scan_timer.sv
// Digit-slot prescaler and digit counter; flags the blanking window at the start of
// every slot and the last cycle of the digit3 slot as the frame boundary.
module seg_scan_timer #(
    parameter int SCAN_DIV  = 16384,
    parameter int BLANK_CYC = 64
) (
    input  logic       clk,
    input  logic       clear,
    output logic [1:0] digit,
    output logic       blank,
    output logic       frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_reg;
    logic [1:0]    digit_reg;
    logic          slot_end;

    assign slot_end = (presc_reg == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            presc_reg <= '0;
            digit_reg <= 2'd0;
        end else if (slot_end) begin
            presc_reg <= '0;
            digit_reg <= digit_reg + 2'd1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign digit      = digit_reg;
    assign blank      = (presc_reg < PW'(BLANK_CYC));
    assign frame_tick = slot_end && (digit_reg == 2'd3);

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a 4-digit multiplexed display with a minimum hold, switched only
// at frame boundaries; owns the shadow frame and the registered seg/com pin drive.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int SCAN_DIV  = 16384,
    parameter int BLANK_CYC = 64,
    parameter int MIN_HOLD  = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    seg_display_arbiter_if.slave  bus
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MIN_HOLD + 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

    logic [1:0] digit;
    logic       blank;
    logic       frame_tick;

    seg_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan (
        .clk        (clk),
        .clear      (clear),
        .digit      (digit),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    logic [FRAME_W-1:0] frame_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_frame
            assign frame_arr[gi] = bus.frame_i[gi*FRAME_W +: FRAME_W];
        end
    endgenerate

    arb_state_t         state_reg;
    logic [N_REQ-1:0]   grant_reg;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [HOLD_W-1:0]  hold_cnt_reg;
    logic [FRAME_W-1:0] shadow_reg;
    logic [SEG_W-1:0]   seg_reg;
    logic [DIGITS-1:0]  com_reg;

    // First requester after rr_ptr in circular order; the owner itself is visited last,
    // so a hit on anyone else always beats keeping the current owner.
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_reg;
        cand       = rr_ptr_reg;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == PTR_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    logic             owner_req;
    logic             others_req;
    logic             hold_reached;
    logic             switch_owner;
    logic [HOLD_W-1:0] hold_next;

    assign owner_req    = bus.req[rr_ptr_reg];
    assign others_req   = |(bus.req & ~grant_reg);
    assign hold_reached = (int'(hold_cnt_reg) + 1) >= MIN_HOLD;
    assign hold_next    = (hold_cnt_reg == HOLD_MAX) ? HOLD_MAX : hold_cnt_reg + 1'b1;
    assign switch_owner = (state_reg == IDLE) || !owner_req || (hold_reached && others_req);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= PTR_W'(N_REQ - 1);
            hold_cnt_reg <= '0;
            shadow_reg   <= '0;
        end else if (frame_tick) begin
            if (switch_owner) begin
                hold_cnt_reg <= '0;
                if (pick_found) begin
                    state_reg  <= OWN;
                    grant_reg  <= N_REQ'(1) << pick_idx;
                    rr_ptr_reg <= pick_idx;
                    shadow_reg <= frame_arr[pick_idx];
                end else begin
                    state_reg  <= IDLE;
                    grant_reg  <= '0;
                    shadow_reg <= '0;
                end
            end else begin
                // Owner keeps the display; re-latch its frame so updates appear next frame.
                hold_cnt_reg <= hold_next;
                shadow_reg   <= frame_arr[rr_ptr_reg];
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            seg_reg <= SEG_BLANK;
            com_reg <= COM_OFF;
        end else if (blank) begin
            seg_reg <= SEG_BLANK;
            com_reg <= COM_OFF;
        end else begin
            seg_reg <= digit_slice(shadow_reg, digit);
            com_reg <= com_enc(digit);
        end
    end

    assign bus.grant      = grant_reg;
    assign bus.seg        = seg_reg;
    assign bus.com        = com_reg;
    assign bus.frame_tick = frame_tick;

endmodule
